// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 widths, FSM states, lane geometry.
// No logic; imported by load_store_unit and lsu_load_extract.
// No flow control here.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_extract.sv
// Load lane select with sign/zero extension of the memory word.
// Latency: combinational. Backpressure: none.
// Unknown funct3 yields zero.
module lsu_load_extract
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  output logic [WORD_W-1:0] data
);

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I MEM-stage load/store initiator; sub-word stores run read-modify-write. LSU_MISALIGN_TRAP_EN enables misalignment trapping.
// Latency: loads/SW 1 cycle, SB/SH 2 cycles (read+stall, then merge write).
// Backpressure: o_stall held for the read cycle of SB/SH only, never two cycles running.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic              i_load,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_store_data,
  output logic [31:0]       o_load_data,
  output logic              o_stall,
  output logic              o_misaligned,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [31:0]       o_mem_write_data,
  input  logic [31:0]       i_mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lane_q;
  logic              half_q;
  logic [15:0]       data_q;

  logic              is_ld, is_st, legal_ld, legal_st, is_half, is_word;
  logic              misaligned, do_ld, do_st, start_rmw;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       extract_data, merge_data;

  assign is_ld     = i_valid & i_load & ~i_store;
  assign is_st     = i_valid & i_store & ~i_load;
  assign legal_ld  = i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  assign legal_st  = i_funct3 inside {F3_B, F3_H, F3_W};
  assign is_half   = (i_funct3[1:0] == 2'b01);
  assign is_word   = (i_funct3 == F3_W);
  assign word_addr = {i_addr[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (state_q == ST_IDLE) && ((is_ld && legal_ld) || (is_st && legal_st)) &&
                      ((is_half && i_addr[0]) || (is_word && (i_addr[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign do_ld = is_ld & legal_ld & ~misaligned;
  assign do_st = is_st & legal_st & ~misaligned;

  lsu_load_extract u_extract (
    .word   (i_mem_read_data),
    .funct3 (i_funct3),
    .lane   (i_addr[1:0]),
    .data   (extract_data)
  );

  always_comb begin
    merge_data = word_q;
    if (half_q) begin
      if (lane_q[1]) merge_data[31:16] = data_q;
      else           merge_data[15:0]  = data_q;
    end else begin
      case (lane_q)
        2'd0:    merge_data[7:0]   = data_q[7:0];
        2'd1:    merge_data[15:8]  = data_q[7:0];
        2'd2:    merge_data[23:16] = data_q[7:0];
        default: merge_data[31:24] = data_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_d          = state_q;
    start_rmw        = 1'b0;
    o_mem_read       = 1'b0;
    o_mem_write      = 1'b0;
    o_mem_address    = '0;
    o_mem_write_data = '0;
    o_load_data      = '0;
    o_stall          = 1'b0;
    o_misaligned     = misaligned;
    case (state_q)
      ST_IDLE: begin
        if (do_ld) begin
          o_mem_read    = 1'b1;
          o_mem_address = word_addr;
          o_load_data   = extract_data;
        end else if (do_st && is_word) begin
          o_mem_write      = 1'b1;
          o_mem_address    = word_addr;
          o_mem_write_data = i_store_data;
        end else if (do_st) begin
          o_mem_read    = 1'b1;
          o_mem_address = word_addr;
          o_stall       = 1'b1;
          start_rmw     = 1'b1;
          state_d       = ST_MERGE;
        end
      end
      ST_MERGE: begin
        o_mem_write      = 1'b1;
        o_mem_address    = addr_q;
        o_mem_write_data = merge_data;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset is synchronous, so outputs are forced quiet to drop a pending merge write.
    if (!i_rst_n) begin
      start_rmw        = 1'b0;
      o_mem_read       = 1'b0;
      o_mem_write      = 1'b0;
      o_mem_address    = '0;
      o_mem_write_data = '0;
      o_load_data      = '0;
      o_stall          = 1'b0;
      o_misaligned     = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      half_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_rmw) begin
        word_q <= i_mem_read_data;
        addr_q <= word_addr;
        lane_q <= i_addr[1:0];
        half_q <= is_half;
        data_q <= i_store_data[15:0];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small behavioural data memory.
// Expectations are queued by the stimulus and popped by a negedge monitor.
module tb_load_store_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_load;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [31:0] o_load_data;
  logic        o_stall;
  logic        o_misaligned;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic [31:0] i_mem_read_data;

  load_store_unit #(.ADDR_W(32)) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_valid          (i_valid),
    .i_load           (i_load),
    .i_store          (i_store),
    .i_funct3         (i_funct3),
    .i_addr           (i_addr),
    .i_store_data     (i_store_data),
    .o_load_data      (o_load_data),
    .o_stall          (o_stall),
    .o_misaligned     (o_misaligned),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_mem_address    (o_mem_address),
    .o_mem_write_data (o_mem_write_data),
    .i_mem_read_data  (i_mem_read_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [31:0] mem [0:15];
  assign i_mem_read_data = mem[o_mem_address[5:2]];
  always @(posedge i_clk) if (o_mem_write === 1'b1) mem[o_mem_address[5:2]] <= o_mem_write_data;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic        stall;
    logic        mis;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  prev_stall = 1'b0;

  task automatic expect_tx(input string nm, input logic rd, input logic wr, input logic stall,
                           input logic mis, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] ldata);
    exp_t e;
    e = '{rd: rd, wr: wr, stall: stall, mis: mis, addr: addr, wdata: wdata, ldata: ldata};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge i_clk) begin
    exp_t  e;
    exp_t  a;
    string nm;
    if (o_stall === 1'b1) begin
      n_cmp++;
      if (prev_stall === 1'b1) begin
        n_bad++;
        $display("FAIL stall_twice: o_stall high two cycles running, required at most one");
      end
    end
    prev_stall = o_stall;
    if (o_mem_read === 1'b1 || o_mem_write === 1'b1 || o_misaligned === 1'b1) begin
      a = '{rd: o_mem_read, wr: o_mem_write, stall: o_stall, mis: o_misaligned,
            addr: o_mem_address, wdata: o_mem_write_data, ldata: o_load_data};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_tx: rd=%b wr=%b addr=%h wdata=%h, required no activity",
                 a.rd, a.wr, a.addr, a.wdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got rd=%b wr=%b st=%b mis=%b addr=%h wd=%h ld=%h, required rd=%b wr=%b st=%b mis=%b addr=%h wd=%h ld=%h",
                   nm, a.rd, a.wr, a.stall, a.mis, a.addr, a.wdata, a.ldata,
                   e.rd, e.wr, e.stall, e.mis, e.addr, e.wdata, e.ldata);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_ctl"}, {28'd0, o_mem_read, o_mem_write, o_stall, o_misaligned}, 32'd0);
    chk({nm, "_dat"}, o_mem_address | o_mem_write_data | o_load_data, 32'd0);
  endtask

  task automatic issue(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge i_clk);
    #1;
    i_valid = v; i_load = ld; i_store = st; i_funct3 = f3; i_addr = a; i_store_data = d;
  endtask

  task automatic idle();
    issue(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    i_rst_n = 1'b0;
    i_valid = 1'b1; i_load = 1'b1; i_store = 1'b0; i_funct3 = 3'b010;
    i_addr = 32'h10; i_store_data = 32'd0;
    @(negedge i_clk);
    chk_quiet("reset_load_held");
    issue(1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge i_clk);
    chk_quiet("reset_state");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    expect_tx("sw_deadbeef", 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 32'd0);
    issue(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    expect_tx("lw_10", 1, 0, 0, 0, 32'h10, 32'd0, 32'hDEADBEEF);
    issue(1, 1, 0, 3'b010, 32'h10, 32'd0);

    expect_tx("sb_read", 1, 0, 1, 0, 32'h10, 32'd0, 32'd0);
    issue(1, 0, 1, 3'b000, 32'h11, 32'h000000AA);
    expect_tx("sb_merge", 0, 1, 0, 0, 32'h10, 32'hDEADAAEF, 32'd0);
    idle();

    expect_tx("sw_restore", 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 32'd0);
    issue(1, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
    expect_tx("sh_read", 1, 0, 1, 0, 32'h10, 32'd0, 32'd0);
    issue(1, 0, 1, 3'b001, 32'h12, 32'h00001234);
    expect_tx("sh_merge", 0, 1, 0, 0, 32'h10, 32'h1234BEEF, 32'd0);
    idle();

    expect_tx("sw_80ff1234", 0, 1, 0, 0, 32'h10, 32'h80FF1234, 32'd0);
    issue(1, 0, 1, 3'b010, 32'h10, 32'h80FF1234);
    expect_tx("lb_13", 1, 0, 0, 0, 32'h10, 32'd0, 32'hFFFFFF80);
    issue(1, 1, 0, 3'b000, 32'h13, 32'd0);
    expect_tx("lbu_13", 1, 0, 0, 0, 32'h10, 32'd0, 32'h00000080);
    issue(1, 1, 0, 3'b100, 32'h13, 32'd0);
    expect_tx("lh_12", 1, 0, 0, 0, 32'h10, 32'd0, 32'hFFFF80FF);
    issue(1, 1, 0, 3'b001, 32'h12, 32'd0);
    expect_tx("lhu_12", 1, 0, 0, 0, 32'h10, 32'd0, 32'h000080FF);
    issue(1, 1, 0, 3'b101, 32'h12, 32'd0);
    expect_tx("lb_11", 1, 0, 0, 0, 32'h10, 32'd0, 32'h00000012);
    issue(1, 1, 0, 3'b000, 32'h11, 32'd0);
    expect_tx("lh_10", 1, 0, 0, 0, 32'h10, 32'd0, 32'h00001234);
    issue(1, 1, 0, 3'b001, 32'h10, 32'd0);

    expect_tx("sb0_read", 1, 0, 1, 0, 32'h10, 32'd0, 32'd0);
    issue(1, 0, 1, 3'b000, 32'h10, 32'hFFFFFF55);
    expect_tx("sb0_merge", 0, 1, 0, 0, 32'h10, 32'h80FF1255, 32'd0);
    idle();
    expect_tx("lw_after_sb0", 1, 0, 0, 0, 32'h10, 32'd0, 32'h80FF1255);
    issue(1, 1, 0, 3'b010, 32'h10, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
    expect_tx("lw_11_trap", 0, 0, 0, 1, 32'd0, 32'd0, 32'd0);
    issue(1, 1, 0, 3'b010, 32'h11, 32'd0);
    expect_tx("lh_13_trap", 0, 0, 0, 1, 32'd0, 32'd0, 32'd0);
    issue(1, 1, 0, 3'b001, 32'h13, 32'd0);
`else
    expect_tx("lw_11_align", 1, 0, 0, 0, 32'h10, 32'd0, 32'h80FF1255);
    issue(1, 1, 0, 3'b010, 32'h11, 32'd0);
    expect_tx("lh_13_lane", 1, 0, 0, 0, 32'h10, 32'd0, 32'hFFFF80FF);
    issue(1, 1, 0, 3'b001, 32'h13, 32'd0);
`endif

    issue(0, 1, 0, 3'b010, 32'h10, 32'd0);
    @(negedge i_clk); chk_quiet("noop_invalid");
    issue(1, 1, 0, 3'b011, 32'h10, 32'd0);
    @(negedge i_clk); chk_quiet("noop_f3_011");
    issue(1, 0, 1, 3'b100, 32'h10, 32'h12345678);
    @(negedge i_clk); chk_quiet("noop_store_bu");
    issue(1, 1, 1, 3'b010, 32'h10, 32'h12345678);
    @(negedge i_clk); chk_quiet("noop_ld_and_st");

    expect_tx("sw_20", 0, 1, 0, 0, 32'h20, 32'h11223344, 32'd0);
    issue(1, 0, 1, 3'b010, 32'h20, 32'h11223344);
    expect_tx("sb_rst_read", 1, 0, 1, 0, 32'h20, 32'd0, 32'd0);
    issue(1, 0, 1, 3'b000, 32'h20, 32'h00000055);
    @(posedge i_clk); #1;
    i_rst_n = 1'b0; i_valid = 1'b0;
    @(negedge i_clk); chk_quiet("rst_in_merge");
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_clk); chk_quiet("after_rst");
    chk("mem_unchanged", mem[8], 32'h11223344);
    expect_tx("lw_20_after_rst", 1, 0, 0, 0, 32'h20, 32'd0, 32'h11223344);
    issue(1, 1, 0, 3'b010, 32'h20, 32'd0);

    idle();
    idle();
    @(negedge i_clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
